// File: rtl/wb_forward_pipe.sv
// wb_forward_pipe: back half of the integer pipeline (EX -> MEM -> WB).
// Holds the MEM and WB result registers and drives the regfile write port
// and the three ID bypass taps (EX, MEM, WB). Merges the synchronous data
// SRAM read word into the MEM tap for loads and flags load-use hazards.
// The EX tap data output is named ex_to_id_wdata because ex_wdata is
// already taken by the EX result input.
// Build option: define LOAD_SUBWORD_EN to enable byte/halfword load
// extraction in MEM; without it a load always returns the whole SRAM word.

module wb_forward_pipe #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          stall_i,
   input  logic          flush_i,
   input  logic          ex_valid,
   input  logic          ex_we,
   input  logic [AW-1:0] ex_waddr,
   input  logic [DW-1:0] ex_wdata,
   input  logic          ex_is_load,
   input  logic [2:0]    ex_ld_type,
   input  logic [1:0]    ex_addr_lo,
   input  logic [DW-1:0] data_sram_rdata,
   input  logic          id_re1,
   input  logic          id_re2,
   input  logic [AW-1:0] id_raddr1,
   input  logic [AW-1:0] id_raddr2,
   output logic          ex_to_id_we,
   output logic [AW-1:0] ex_to_id_waddr,
   output logic [DW-1:0] ex_to_id_wdata,
   output logic          mem_to_id_we,
   output logic [AW-1:0] mem_to_id_waddr,
   output logic [DW-1:0] mem_wdata,
   output logic          wb_to_id_we,
   output logic [AW-1:0] wb_to_id_waddr,
   output logic [DW-1:0] wb_wdata,
   output logic          rf_we,
   output logic [AW-1:0] rf_waddr,
   output logic [DW-1:0] rf_wdata,
   output logic          load_use_stall
);

   // ------------------------------------------------------------------
   // EX stage: combinational tap and load-use detection
   // ------------------------------------------------------------------
   logic ex_writes_rd;
   logic id_hits_ex;

   // A write to r0 is never a real write, so it never drives a tap.
   assign ex_writes_rd = ex_valid & ex_we & (ex_waddr != '0);
   assign id_hits_ex   = (id_re1 & (id_raddr1 == ex_waddr)) |
                         (id_re2 & (id_raddr2 == ex_waddr));

   // Load data is not known until MEM, so a load never feeds the EX tap.
   assign ex_to_id_we    = ex_writes_rd & ~ex_is_load;
   assign ex_to_id_waddr = ex_waddr;
   assign ex_to_id_wdata = ex_wdata;
   assign load_use_stall = ex_writes_rd & ex_is_load & id_hits_ex;

   // ------------------------------------------------------------------
   // MEM stage registers
   // ------------------------------------------------------------------
   logic          mem_valid;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [DW-1:0] mem_data;
   logic          mem_is_load;
`ifdef LOAD_SUBWORD_EN
   logic [2:0]    mem_ld_type;
   logic [1:0]    mem_addr_lo;
`endif

   // Capture EX into MEM; stall holds (and overrides flush), flush injects a bubble.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      if (!resetn) begin
         mem_valid   <= 1'b0;
         mem_we      <= 1'b0;
         mem_waddr   <= '0;
         mem_data    <= '0;
         mem_is_load <= 1'b0;
`ifdef LOAD_SUBWORD_EN
         mem_ld_type <= '0;
         mem_addr_lo <= '0;
`endif
      end else if (!stall_i) begin
         mem_valid   <= ex_valid & ~flush_i;
         mem_we      <= ex_we;
         mem_waddr   <= ex_waddr;
         mem_data    <= ex_wdata;
         mem_is_load <= ex_is_load;
`ifdef LOAD_SUBWORD_EN
         mem_ld_type <= ex_ld_type;
         mem_addr_lo <= ex_addr_lo;
`endif
      end
   end

   // ------------------------------------------------------------------
   // Load data extraction
   // ------------------------------------------------------------------
   logic [DW-1:0] load_data;

`ifdef LOAD_SUBWORD_EN
   typedef enum logic [2:0] {
      LD_W  = 3'd0,
      LD_B  = 3'd1,
      LD_BU = 3'd2,
      LD_H  = 3'd3,
      LD_HU = 3'd4
   } ld_type_e;

   // Little-endian byte/half select with sign or zero extension.
   function automatic logic [DW-1:0] load_extract(
      input logic [DW-1:0] word,
      input logic [2:0]    ld_type,
      input logic [1:0]    addr_lo
   );
      logic [7:0]    byte_sel;
      logic [15:0]   half_sel;
      logic [DW-1:0] result;
      case (addr_lo)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase
      half_sel = addr_lo[1] ? word[31:16] : word[15:0];
      case (ld_type_e'(ld_type))
         LD_B:    result = {{(DW-8){byte_sel[7]}}, byte_sel};
         LD_BU:   result = {{(DW-8){1'b0}}, byte_sel};
         LD_H:    result = {{(DW-16){half_sel[15]}}, half_sel};
         LD_HU:   result = {{(DW-16){1'b0}}, half_sel};
         default: result = word;
      endcase
      return result;
   endfunction

   assign load_data = load_extract(data_sram_rdata, mem_ld_type, mem_addr_lo);
`else
   // Type and alignment are only needed for sub-word loads.
   logic unused_ld_info;
   assign unused_ld_info = ^{ex_ld_type, ex_addr_lo};
   assign load_data      = data_sram_rdata;
`endif

   // ------------------------------------------------------------------
   // MEM tap
   // ------------------------------------------------------------------
   logic [DW-1:0] mem_tap_data;

   // Loads take the SRAM word, everything else the ALU result captured from EX.
   always_comb begin
      // NOTE: default assigned first so no path leaves the signal unassigned
      // (which would infer a latch).
      mem_tap_data = mem_data;
      if (mem_is_load) begin
         mem_tap_data = load_data;
      end
   end

   assign mem_to_id_we    = mem_valid & mem_we & (mem_waddr != '0);
   assign mem_to_id_waddr = mem_waddr;
   assign mem_wdata       = mem_tap_data;

   // ------------------------------------------------------------------
   // WB stage registers
   // ------------------------------------------------------------------
   logic          wb_we;
   logic [AW-1:0] wb_waddr;
   logic [DW-1:0] wb_data;

   // Capture the MEM tap into WB; a held WB simply repeats the same write.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wb_we    <= 1'b0;
         wb_waddr <= '0;
         wb_data  <= '0;
      end else if (!stall_i) begin
         wb_we    <= mem_to_id_we;
         wb_waddr <= mem_to_id_waddr;
         wb_data  <= mem_tap_data;
      end
   end

   assign wb_to_id_we    = wb_we;
   assign wb_to_id_waddr = wb_waddr;
   assign wb_wdata       = wb_data;

   // The regfile write port is the WB tap itself.
   assign rf_we    = wb_we;
   assign rf_waddr = wb_waddr;
   assign rf_wdata = wb_data;

endmodule

// File: tb/tb_wb_forward_pipe.sv
// tb_wb_forward_pipe: directed scenarios plus randomized traffic for
// wb_forward_pipe, checked against an instruction-level reference model.
// Honours LOAD_SUBWORD_EN the same way as the design.

module tb_wb_forward_pipe;

   logic        clk = 1'b0;
   logic        resetn;
   logic        stall_i, flush_i;
   logic        ex_valid, ex_we, ex_is_load;
   logic [4:0]  ex_waddr;
   logic [31:0] ex_wdata;
   logic [2:0]  ex_ld_type;
   logic [1:0]  ex_addr_lo;
   logic [31:0] data_sram_rdata;
   logic        id_re1, id_re2;
   logic [4:0]  id_raddr1, id_raddr2;
   logic        ex_to_id_we, mem_to_id_we, wb_to_id_we, rf_we, load_use_stall;
   logic [4:0]  ex_to_id_waddr, mem_to_id_waddr, wb_to_id_waddr, rf_waddr;
   logic [31:0] ex_to_id_wdata, mem_wdata, wb_wdata, rf_wdata;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   wb_forward_pipe #(.DW(32), .AW(5)) dut (
      .clk(clk), .resetn(resetn), .stall_i(stall_i), .flush_i(flush_i),
      .ex_valid(ex_valid), .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
      .ex_is_load(ex_is_load), .ex_ld_type(ex_ld_type), .ex_addr_lo(ex_addr_lo),
      .data_sram_rdata(data_sram_rdata),
      .id_re1(id_re1), .id_re2(id_re2), .id_raddr1(id_raddr1), .id_raddr2(id_raddr2),
      .ex_to_id_we(ex_to_id_we), .ex_to_id_waddr(ex_to_id_waddr), .ex_to_id_wdata(ex_to_id_wdata),
      .mem_to_id_we(mem_to_id_we), .mem_to_id_waddr(mem_to_id_waddr), .mem_wdata(mem_wdata),
      .wb_to_id_we(wb_to_id_we), .wb_to_id_waddr(wb_to_id_waddr), .wb_wdata(wb_wdata),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .load_use_stall(load_use_stall)
   );

   // Reference model: the instruction sitting in MEM and the result sitting in WB.
   typedef struct packed {
      logic        valid;
      logic        we;
      logic [4:0]  rd;
      logic [31:0] alu;
      logic        is_load;
      logic [2:0]  ld_type;
      logic [1:0]  lo;
   } mem_inst_t;

   typedef struct packed {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] value;
   } wb_result_t;

   mem_inst_t  m_mem;
   wb_result_t m_wb;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Sub-word load value computed arithmetically from the loaded word.
   function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] t,
                                           input logic [1:0] lo);
      int unsigned b;
      int unsigned h;
      b = (w >> (8 * lo)) & 32'hFF;
      h = (w >> (16 * lo[1])) & 32'hFFFF;
      case (t)
         3'd1:    return (b >= 128) ? b - 256 : b;
         3'd2:    return b;
         3'd3:    return (h >= 32768) ? h - 65536 : h;
         3'd4:    return h;
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] model_mem_value();
      if (!m_mem.is_load) return m_mem.alu;
`ifdef LOAD_SUBWORD_EN
      return extract(data_sram_rdata, m_mem.ld_type, m_mem.lo);
`else
      return data_sram_rdata;
`endif
   endfunction

   function automatic logic model_mem_we();
      return m_mem.valid && m_mem.we && (m_mem.rd != 5'd0);
   endfunction

   task automatic check_outputs();
      logic ex_real_write;
      logic reads_load;
      ex_real_write = ex_valid && ex_we && (ex_waddr != 5'd0);
      reads_load = (id_re1 && id_raddr1 == ex_waddr) || (id_re2 && id_raddr2 == ex_waddr);
      check("ex_tap_we",    ex_to_id_we, ex_real_write && !ex_is_load);
      check("ex_tap_waddr", ex_to_id_waddr, ex_waddr);
      check("ex_tap_wdata", ex_to_id_wdata, ex_wdata);
      check("load_use",     load_use_stall, ex_real_write && ex_is_load && reads_load);
      check("mem_tap_we",   mem_to_id_we, model_mem_we());
      check("mem_tap_waddr", mem_to_id_waddr, m_mem.rd);
      check("mem_tap_wdata", mem_wdata, model_mem_value());
      check("wb_tap_we",    wb_to_id_we, m_wb.we);
      check("wb_tap_waddr", wb_to_id_waddr, m_wb.rd);
      check("wb_tap_wdata", wb_wdata, m_wb.value);
      check("rf_we",        rf_we, m_wb.we);
      check("rf_waddr",     rf_waddr, m_wb.rd);
      check("rf_wdata",     rf_wdata, m_wb.value);
   endtask

   // One cycle: check current outputs, advance the model, cross the clock edge.
   task automatic step();
      #1 check_outputs();
      if (!resetn) begin
         m_mem = '0;
         m_wb  = '0;
      end else if (!stall_i) begin
         m_wb  = '{we: model_mem_we(), rd: m_mem.rd, value: model_mem_value()};
         m_mem = '{valid: ex_valid && !flush_i, we: ex_we, rd: ex_waddr, alu: ex_wdata,
                   is_load: ex_is_load, ld_type: ex_ld_type, lo: ex_addr_lo};
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      resetn = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
      ex_valid = 1'b0; ex_we = 1'b0; ex_is_load = 1'b0; ex_waddr = '0;
      ex_wdata = '0; ex_ld_type = '0; ex_addr_lo = '0;
      id_re1 = 1'b0; id_re2 = 1'b0; id_raddr1 = '0; id_raddr2 = '0;
   endtask

   task automatic ex_alu(input logic [4:0] rd, input logic [31:0] val);
      ex_valid = 1'b1; ex_we = 1'b1; ex_is_load = 1'b0; ex_waddr = rd; ex_wdata = val;
   endtask

   task automatic ex_load(input logic [4:0] rd, input logic [2:0] t, input logic [1:0] lo);
      ex_valid = 1'b1; ex_we = 1'b1; ex_is_load = 1'b1; ex_waddr = rd;
      ex_wdata = 32'hBAD0_BAD0; ex_ld_type = t; ex_addr_lo = lo;
   endtask

   logic [2:0]  sub_type [7] = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd0, 3'd7};
   logic [1:0]  sub_lo   [7] = '{2'd3, 2'd3, 2'd0, 2'd2, 2'd2, 2'd1, 2'd0};
   logic [31:0] sub_exp  [7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_7F01, 32'hFFFF_80FF,
                                 32'h0000_80FF, 32'h80FF_7F01, 32'h80FF_7F01};

   initial begin
      idle();
      data_sram_rdata = '0;
      resetn = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      m_mem = '0;
      m_wb  = '0;

      // Reset state
      #1;
      check("reset_mem_we", mem_to_id_we, 1'b0);
      check("reset_rf_we", rf_we, 1'b0);
      check("reset_rf_wdata", rf_wdata, 32'h0);
      idle();
      step();

      // ALU chain through EX, MEM, WB
      ex_alu(5'd3, 32'h11);
      step();
      ex_alu(5'd3, 32'h22);
      #1;
      check("chain_mem_wdata", mem_wdata, 32'h11);
      check("chain_mem_we", mem_to_id_we, 1'b1);
      step();
      idle();
      #1;
      check("chain_rf_we", rf_we, 1'b1);
      check("chain_rf_waddr", rf_waddr, 5'd3);
      check("chain_rf_wdata", rf_wdata, 32'h11);
      step();

      // Load-use hazard detection
      ex_load(5'd5, 3'd0, 2'd0);
      id_re1 = 1'b1; id_raddr1 = 5'd5;
      #1;
      check("lu_stall_hit", load_use_stall, 1'b1);
      check("lu_no_ex_tap", ex_to_id_we, 1'b0);
      id_raddr1 = 5'd6;
      #1 check("lu_stall_miss", load_use_stall, 1'b0);
      ex_waddr = 5'd0; id_raddr1 = 5'd0;
      #1 check("lu_stall_r0", load_use_stall, 1'b0);
      ex_waddr = 5'd5; id_re1 = 1'b0;
      step();

      // Load word merged from SRAM in MEM
      idle();
      data_sram_rdata = 32'hDEAD_BEEF;
      #1;
      check("ld_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      check("ld_mem_waddr", mem_to_id_waddr, 5'd5);
      step();
      #1 check("ld_rf_wdata", rf_wdata, 32'hDEAD_BEEF);
      step();

      // Stall with MEM and WB loaded; flush during stall is ignored
      ex_alu(5'd10, 32'hA5A5_0001);
      step();
      ex_alu(5'd11, 32'hA5A5_0002);
      step();
      stall_i = 1'b1; flush_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ex_alu(5'(12 + i), $urandom);
         step();
      end
      idle();
      step();
      step();

      // Flush injects a bubble
      ex_alu(5'd7, 32'h7777);
      flush_i = 1'b1;
      step();
      idle();
      #1 check("flush_mem_we", mem_to_id_we, 1'b0);
      step();
      #1 check("flush_rf_we", rf_we, 1'b0);
      step();

      // Sub-word load extraction
      for (int i = 0; i < 7; i++) begin
         ex_load(5'd9, sub_type[i], sub_lo[i]);
         step();
         idle();
         data_sram_rdata = 32'h80FF_7F01;
`ifdef LOAD_SUBWORD_EN
         #1 check($sformatf("subword_%0d", i), mem_wdata, sub_exp[i]);
`else
         #1 check($sformatf("subword_%0d", i), mem_wdata, 32'h80FF_7F01);
`endif
         step();
      end

      // Reset while stalled clears everything
      ex_alu(5'd4, 32'h4444);
      step();
      step();
      stall_i = 1'b1; flush_i = 1'b1; resetn = 1'b0;
      step();
      idle();
      #1;
      check("rst_stall_mem_we", mem_to_id_we, 1'b0);
      check("rst_stall_rf_we", rf_we, 1'b0);
      step();

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         resetn     = ($urandom_range(0, 79) != 0);
         stall_i    = ($urandom_range(0, 3) == 0);
         flush_i    = ($urandom_range(0, 5) == 0);
         ex_valid   = ($urandom_range(0, 4) != 0);
         ex_we      = ($urandom_range(0, 3) != 0);
         ex_is_load = ($urandom_range(0, 2) == 0);
         ex_waddr   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                  : 5'($urandom_range(0, 7));
         ex_wdata   = $urandom;
         ex_ld_type = 3'($urandom_range(0, 7));
         ex_addr_lo = 2'($urandom_range(0, 3));
         data_sram_rdata = $urandom;
         id_re1     = ($urandom_range(0, 1) == 1);
         id_re2     = ($urandom_range(0, 1) == 1);
         id_raddr1  = ($urandom_range(0, 1) == 1) ? ex_waddr : 5'($urandom_range(0, 7));
         id_raddr2  = ($urandom_range(0, 2) == 0) ? ex_waddr : 5'($urandom_range(0, 7));
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
